// File: rtl/unidade_controle_jogo_pkg.sv
// Shared definitions for the memory-game control unit: state codes, default timeout, output decode.
// Latency: none (types, constants and a pure function).
// Backpressure: not applicable.
package unidade_controle_jogo_pkg;

  // State codes double as the debug value shown on the 7-segment display.
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  // Cycles allowed in espera before the move is declared timed out.
  localparam int TIMEOUT_PADRAO = 5000;

  // Control and status outputs, grouped so they can be registered together.
  typedef struct packed {
    logic zeraC;
    logic contaC;
    logic zeraR;
    logic registraR;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  // Moore decode: which outputs are asserted while sitting in a given state.
  function automatic saidas_t decodifica_saidas(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARACAO: begin
        s.zeraC = 1'b1;
        s.zeraR = 1'b1;
      end
      REGISTRA:    s.registraR = 1'b1;
      PROXIMO:     s.contaC = 1'b1;
      FIM_ACERTO: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      FIM_ERRO: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto  = 1'b1;
        s.timeout = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// Inactivity counter: counts cycles while enabled, flags the last allowed cycle (TIMEOUT-1).
// Latency: count updates one cycle after enable; flag is combinational from the count.
// Backpressure: none; clear has priority over enable, TIMEOUT=0 keeps the flag low.
module unidade_controle_jogo_contador_timeout #(
  parameter int TIMEOUT = 5000,
  parameter int TW      = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fim
);

  localparam logic [TW-1:0] ULTIMO = TW'(TIMEOUT - 1);

  logic [TW-1:0] contagem;

  // Count up while enabled; reset and clear both return the count to zero.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      contagem <= '0;
    end else if (enable) begin
      contagem <= contagem + 1'b1;
    end
  end

  assign fim = (TIMEOUT != 0) && (contagem == ULTIMO);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the memory game: sequences zero/wait/register/compare/advance, with move timeout.
// Latency: outputs are registered and change one cycle after each transition edge (Moore).
// Backpressure: none; jogada_feita is consumed only in espera, iniciar only in inicial and fim_* states.
module unidade_controle_jogo
  import unidade_controle_jogo_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_PADRAO,
  parameter int TW      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fimC,
  input  logic       jogada_feita,
  input  logic       igual,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t estado;
  estado_t estado_prox;
  saidas_t saidas;
  logic    limpa_cont;
  logic    conta_cont;
  logic    fim_cont;

  // Counter runs only in espera and is zero on entry and in every other state.
  assign conta_cont = (estado == ESPERA);
  assign limpa_cont = (estado != ESPERA) || (estado_prox != ESPERA);

  unidade_controle_jogo_contador_timeout #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_contador_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (limpa_cont),
    .enable (conta_cont),
    .fim    (fim_cont)
  );

  // Next-state rules; a move in the same cycle as timeout expiry takes precedence.
  always_comb begin
    estado_prox = estado;
    case (estado)
      INICIAL:    estado_prox = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO: estado_prox = ESPERA;
      ESPERA: begin
        if (jogada_feita)  estado_prox = REGISTRA;
        else if (fim_cont) estado_prox = FIM_TIMEOUT;
        else               estado_prox = ESPERA;
      end
      REGISTRA:   estado_prox = COMPARACAO;
      COMPARACAO: begin
        if (!igual)    estado_prox = FIM_ERRO;
        else if (fimC) estado_prox = FIM_ACERTO;
        else           estado_prox = PROXIMO;
      end
      PROXIMO:    estado_prox = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                  estado_prox = iniciar ? PREPARACAO : estado;
      default:    estado_prox = INICIAL;
    endcase
  end

  // State register with outputs registered from the decode of the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
      saidas <= '0;
    end else begin
      estado <= estado_prox;
      saidas <= decodifica_saidas(estado_prox);
    end
  end

  assign zeraC     = saidas.zeraC;
  assign contaC    = saidas.contaC;
  assign zeraR     = saidas.zeraR;
  assign registraR = saidas.registraR;
  assign pronto    = saidas.pronto;
  assign acertou   = saidas.acertou;
  assign errou     = saidas.errou;
  assign timeout   = saidas.timeout;
  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
module tb_unidade_controle_jogo;

  localparam int TMO = 50;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       fimC;
  logic       jogada_feita;
  logic       igual;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  int errors;
  int checks;
  int tot_conta;
  int tot_zera;

  unidade_controle_jogo #(.TIMEOUT(TMO), .TW(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .fimC         (fimC),
    .jogada_feita (jogada_feita),
    .igual        (igual),
    .zeraC        (zeraC),
    .contaC       (contaC),
    .zeraR        (zeraR),
    .registraR    (registraR),
    .pronto       (pronto),
    .acertou      (acertou),
    .errou        (errou),
    .timeout      (timeout),
    .db_estado    (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Running totals of cycles with the counter-clear and counter-advance commands asserted.
  initial begin
    tot_conta = 0;
    tot_zera  = 0;
  end
  always @(negedge clock) begin
    tot_conta <= tot_conta + int'(contaC);
    tot_zera  <= tot_zera + int'(zeraC);
  end

  // Output vector order: {zeraC, zeraR, registraR, contaC, pronto, acertou, errou, timeout}
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_PREP = 8'b1100_0000;
  localparam logic [7:0] O_REG  = 8'b0010_0000;
  localparam logic [7:0] O_PROX = 8'b0001_0000;
  localparam logic [7:0] O_HIT  = 8'b0000_1100;
  localparam logic [7:0] O_MISS = 8'b0000_1010;
  localparam logic [7:0] O_TOUT = 8'b0000_1001;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_state(input string tag, input logic [3:0] code, input logic [7:0] outs);
    chk({tag, ".estado"}, 32'(db_estado), 32'(code));
    chk({tag, ".saidas"}, 32'({zeraC, zeraR, registraR, contaC, pronto, acertou, errou, timeout}), 32'(outs));
  endtask

  // One game. The expected ending comes from game-level rules: the first move that waits
  // TMO cycles or more times out, otherwise the first wrong move misses, otherwise the
  // final move hits; contaC fires once per correct move that is not the last one.
  task automatic play(input int nmoves, input int miss_at, input int to_at, input int tie_at);
    int         d;
    int         base_conta;
    int         base_zera;
    int         exp_conta;
    logic [3:0] exp_end;
    logic [7:0] exp_out;
    bit         done;

    exp_conta = nmoves - 1;
    exp_end   = 4'hA;
    exp_out   = O_HIT;
    for (int i = 0; i < nmoves; i++) begin
      if (i == to_at) begin
        exp_conta = i; exp_end = 4'hD; exp_out = O_TOUT; break;
      end
      if (i == miss_at) begin
        exp_conta = i; exp_end = 4'hE; exp_out = O_MISS; break;
      end
    end

    base_conta = tot_conta;
    base_zera  = tot_zera;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    expect_state("prep", 4'h1, O_PREP);
    step();
    expect_state("espera0", 4'h2, O_NONE);

    done = 1'b0;
    for (int i = 0; i < nmoves && !done; i++) begin
      igual = (i != miss_at);
      fimC  = (i == nmoves - 1);
      if (i == to_at) begin
        for (int c = 1; c < TMO; c++) begin
          iniciar = 1'($urandom);
          step();
        end
        iniciar = 1'b0;
        chk("espera_last_cycle", 32'(db_estado), 32'h2);
        step();
        expect_state("fim_timeout", 4'hD, O_TOUT);
        done = 1'b1;
      end else begin
        d = (i == tie_at) ? TMO - 1 : int'($urandom_range(0, 12));
        for (int c = 0; c < d; c++) begin
          iniciar = 1'($urandom);
          step();
        end
        iniciar = 1'b0;
        chk("espera_before_move", 32'(db_estado), 32'h2);
        jogada_feita = 1'b1;
        step();
        expect_state((i == tie_at) ? "tie_registra" : "registra", 4'h4, O_REG);
        step();
        jogada_feita = 1'b0;
        expect_state("comparacao", 4'h5, O_NONE);
        step();
        if (i == miss_at) begin
          expect_state("fim_erro", 4'hE, O_MISS);
          done = 1'b1;
        end else if (i == nmoves - 1) begin
          expect_state("fim_acerto", 4'hA, O_HIT);
          done = 1'b1;
        end else begin
          expect_state("proximo", 4'h6, O_PROX);
          step();
          chk("espera_again", 32'(db_estado), 32'h2);
        end
      end
    end

    jogada_feita = 1'b1;
    step();
    step();
    jogada_feita = 1'b0;
    step();
    expect_state("hold_end", exp_end, exp_out);
    chk("contaC_count", 32'(tot_conta - base_conta), 32'(exp_conta));
    chk("zeraC_count", 32'(tot_zera - base_zera), 32'd1);
  endtask

  initial begin
    int nm;
    int sc;
    errors = 0;
    checks = 0;
    reset = 1'b1;
    iniciar = 1'b0;
    fimC = 1'b0;
    jogada_feita = 1'b0;
    igual = 1'b0;
    step();
    step();
    reset = 1'b0;
    expect_state("reset", 4'h0, O_NONE);

    jogada_feita = 1'b1;
    step();
    jogada_feita = 1'b0;
    expect_state("idle_ignores_move", 4'h0, O_NONE);

    reset = 1'b1;
    iniciar = 1'b1;
    step();
    reset = 1'b0;
    iniciar = 1'b0;
    expect_state("reset_beats_iniciar", 4'h0, O_NONE);

    play(16, -1, -1, -1);
    play(5, 2, -1, -1);
    play(4, -1, -1, 1);
    play(3, -1, 0, -1);
    play(3, -1, 2, -1);

    for (int g = 0; g < 10; g++) begin
      nm = int'($urandom_range(1, 16));
      sc = int'($urandom_range(0, 2));
      play(nm,
           (sc == 1) ? int'($urandom_range(0, nm - 1)) : -1,
           (sc == 2) ? int'($urandom_range(0, nm - 1)) : -1,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nm - 1)) : -1);
    end

    // Reset taken in the middle of a game, while in proximo.
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    step();
    igual = 1'b1;
    fimC = 1'b0;
    jogada_feita = 1'b1;
    step();
    jogada_feita = 1'b0;
    step();
    step();
    expect_state("mid_proximo", 4'h6, O_PROX);
    reset = 1'b1;
    step();
    expect_state("mid_reset1", 4'h0, O_NONE);
    step();
    reset = 1'b0;
    expect_state("mid_reset2", 4'h0, O_NONE);
    step();
    expect_state("after_reset_idle", 4'h0, O_NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
Moore control unit that drives the memory-game datapath of experiment 4. It sequences the datapath through zero, wait-for-move, register, compare and advance, consuming the datapath status signals (igual, fimC, jogada_feita). It adds a per-move inactivity timeout. It reports the end result as hit, miss or timeout, with a debug state code for the 7-segment display.

Parameters:
TIMEOUT, 5000, clock cycles allowed in state espera before a timeout; 0 disables the timeout.
TW, 16, width of the internal timeout counter; must satisfy TIMEOUT < 2**TW.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high; forces state inicial.
iniciar  input  1  level start request from the user.
fimC  input  1  datapath address counter at its last position (rco).
jogada_feita  input  1  one-cycle pulse from the datapath edge detector.
igual  input  1  ROM data equals the registered move.
zeraC  output  1  clear the address counter.
contaC  output  1  increment the address counter.
zeraR  output  1  clear the move register.
registraR  output  1  load the move register.
pronto  output  1  game finished (any outcome).
acertou  output  1  finished with all moves correct.
errou  output  1  finished on a wrong move.
timeout  output  1  finished on inactivity.
db_estado  output  4  current state code.

Behaviour:
- Synchronous active-high reset has priority over everything else and is honoured in every state, including mid-game. After reset: state inicial, all outputs 0, db_estado=0x0, timeout counter=0.
- Moore machine: outputs decode only the state register. Output changes appear in the cycle after the transition edge.
- State codes (db_estado) and asserted outputs:
  - inicial 0x0: no outputs asserted.
  - preparacao 0x1: zeraC=1, zeraR=1.
  - espera 0x2: no outputs asserted.
  - registra 0x4: registraR=1.
  - comparacao 0x5: no outputs asserted.
  - proximo 0x6: contaC=1.
  - fim_acerto 0xA: pronto=1, acertou=1.
  - fim_erro 0xE: pronto=1, errou=1.
  - fim_timeout 0xD: pronto=1, timeout=1.
- Transitions:
  - inicial: iniciar=1 -> preparacao; otherwise stay.
  - preparacao -> espera unconditionally; lasts 1 cycle.
  - espera: jogada_feita=1 -> registra; else if the timeout counter reaches TIMEOUT-1 and TIMEOUT!=0 -> fim_timeout; else stay.
  - registra -> comparacao unconditionally. The register loads on the edge leaving registra, so igual is valid in comparacao.
  - comparacao:
    - igual=0 -> fim_erro.
    - igual=1 and fimC=1 -> fim_acerto.
    - igual=1 and fimC=0 -> proximo.
  - proximo -> espera unconditionally; the counter increments on the edge leaving proximo.
  - Any fim_* state: iniciar=1 -> preparacao (restart without reset); otherwise hold with outputs stable.
- Timeout counter:
  - Cleared on every entry to espera.
  - Increments by 1 each cycle spent in espera; held at 0 in all other states.
  - Never wraps, since it leaves espera at TIMEOUT-1.
- Simultaneous events:
  - jogada_feita and timeout expiry in the same cycle: the move wins, go to registra.
  - reset together with iniciar: reset wins.
- iniciar is ignored in all states other than inicial and fim_*.
- jogada_feita is ignored outside espera; no queuing.
- Unused state encodings fall back to inicial on the next edge.

Decomposition:
- Shared package holds:
  - the 4-bit state encodings above (also used by the hex display decoder);
  - the default TIMEOUT constant.
- One natural sub-module, contador_timeout: TW-bit counter with synchronous clear and enable, and a terminal flag at TIMEOUT-1.
- The FSM itself stays in a single module with separate state-register and next-state/output blocks.

Test Plan:
- Reset check: reset=1 for 2 cycles mid-game (e.g. in state proximo) -> next cycle db_estado=0x0, every output 0.
- Full hit, TIMEOUT=50: iniciar pulse, then 16 jogada_feita pulses, each 5 cycles after entering espera, with igual=1 and fimC=1 on the 16th -> end in fim_acerto (0xA), pronto=acertou=1. contaC asserted exactly 15 times; zeraC/zeraR asserted for exactly 1 cycle.
- Miss on 3rd move: igual=0 in comparacao after the 3rd pulse -> fim_erro (0xE), errou=1, acertou=0; contaC asserted exactly 2 times.
- Timeout, TIMEOUT=50: no jogada_feita after reaching espera -> fim_timeout (0xD) exactly 50 cycles after entering espera.
- Timeout tie: jogada_feita on the same cycle the counter=49 -> next state registra (0x4), not 0xD.
- Restart: from fim_erro, iniciar=1 -> preparacao (0x1) with zeraC=zeraR=1, then espera with the timeout counter back at 0.
